// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS controller:
// opcodes, functs, ALU codes, mux selects and FSM states.
package mips_pkg;

  localparam int WORD_SIZE = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic SRCA_PC = 1'b0;
  localparam logic SRCA_RS = 1'b1;

  localparam logic [2:0] SRCB_RT     = 3'b000;
  localparam logic [2:0] SRCB_FOUR   = 3'b001;
  localparam logic [2:0] SRCB_SEXT   = 3'b010;
  localparam logic [2:0] SRCB_ZEXT   = 3'b011;
  localparam logic [2:0] SRCB_BRANCH = 3'b100;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WRITE,
    S_MEM_WB,
    S_ALU_WB,
    S_BRANCH,
    S_JUMP,
    S_JUMP_REG,
    S_TRAP
  } state_e;

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_I      = 3'd1;
  localparam logic [2:0] CLS_LOAD   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;
  localparam logic [2:0] CLS_JUMP   = 3'd5;
  localparam logic [2:0] CLS_JR     = 3'd6;
  localparam logic [2:0] CLS_ILL    = 3'd7;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to class,
// ALU operation, memory access size and extension flags.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] cls,
  output logic [3:0] alu_op,
  output logic [1:0] mem_size,
  output logic       load_unsigned,
  output logic       imm_zext,
  output logic       illegal
);

  always_comb begin
    cls           = CLS_ILL;
    alu_op        = ALU_ADD;
    mem_size      = SIZE_WORD;
    load_unsigned = 1'b0;
    imm_zext      = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        unique case (funct)
          FN_JR:           cls = CLS_JR;
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          default:         cls = CLS_ILL;
        endcase
      end
      OP_J, OP_JAL: cls = CLS_JUMP;
      OP_BEQ, OP_BNE: begin
        cls    = CLS_BRANCH;
        alu_op = ALU_SUB;
      end
      OP_ADDI, OP_ADDIU: cls = CLS_I;
      OP_SLTI: begin
        cls    = CLS_I;
        alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        cls    = CLS_I;
        alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        cls      = CLS_I;
        alu_op   = ALU_AND;
        imm_zext = 1'b1;
      end
      OP_ORI: begin
        cls      = CLS_I;
        alu_op   = ALU_OR;
        imm_zext = 1'b1;
      end
      OP_LUI: begin
        cls      = CLS_I;
        alu_op   = ALU_LUI;
        imm_zext = 1'b1;
      end
      OP_LW: cls = CLS_LOAD;
      OP_LBU: begin
        cls           = CLS_LOAD;
        mem_size      = SIZE_BYTE;
        load_unsigned = 1'b1;
      end
      OP_LHU: begin
        cls           = CLS_LOAD;
        mem_size      = SIZE_HALF;
        load_unsigned = 1'b1;
      end
      OP_SB: begin
        cls      = CLS_STORE;
        mem_size = SIZE_BYTE;
      end
      OP_SH: begin
        cls      = CLS_STORE;
        mem_size = SIZE_HALF;
      end
      OP_SW: cls = CLS_STORE;
      default: cls = CLS_ILL;
    endcase
  end

  assign illegal = (cls == CLS_ILL);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: sequences fetch, decode,
// execute, memory and writeback over a shared datapath.
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] pc_source,
  output logic       alu_src_a,
  output logic [2:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       load_unsigned,
  output logic       busy,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic [2:0] dec_cls;
  logic [3:0] dec_alu_op;
  logic [1:0] dec_mem_size;
  logic       dec_load_unsigned;
  logic       dec_imm_zext;
  logic       dec_illegal;

  mips_ctrl_decode u_decode (
    .opcode        (opcode),
    .funct         (funct),
    .cls           (dec_cls),
    .alu_op        (dec_alu_op),
    .mem_size      (dec_mem_size),
    .load_unsigned (dec_load_unsigned),
    .imm_zext      (dec_imm_zext),
    .illegal       (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_size      = SIZE_BYTE;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RT;
    alu_op        = ALU_ADD;
    reg_dst       = DST_RT;
    mem_to_reg    = M2R_ALU;
    load_unsigned = 1'b0;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_size  = SIZE_WORD;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here while the class resolves
        alu_src_b = SRCB_BRANCH;
        if (dec_illegal) state_d = S_TRAP;
        else begin
          unique case (dec_cls)
            CLS_R:      state_d = S_EXEC_R;
            CLS_I:      state_d = S_EXEC_I;
            CLS_BRANCH: state_d = S_BRANCH;
            CLS_JUMP:   state_d = S_JUMP;
            CLS_JR:     state_d = S_JUMP_REG;
            CLS_LOAD,
            CLS_STORE:  state_d = S_MEM_ADDR;
            default:    state_d = S_TRAP;
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS;
        alu_op    = dec_alu_op;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS;
        alu_src_b = dec_imm_zext ? SRCB_ZEXT : SRCB_SEXT;
        alu_op    = dec_alu_op;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (dec_cls == CLS_R) ? DST_RD : DST_RT;
        state_d   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS;
        alu_src_b = SRCB_SEXT;
        state_d   = (dec_cls == CLS_LOAD) ? S_MEM_READ
                                          : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req  = 1'b1;
        iord     = 1'b1;
        mem_size = dec_mem_size;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        iord     = 1'b1;
        mem_size = dec_mem_size;
        if (mem_ready) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        reg_write     = 1'b1;
        mem_to_reg    = M2R_MEM;
        load_unsigned = dec_load_unsigned;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS;
        alu_op    = ALU_SUB;
        pc_source = PCSRC_ALUOUT;
        // Only combinational path from a datapath flag
        pc_write  = (opcode == OP_BNE) ? !alu_zero : alu_zero;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        if (opcode == OP_JAL) begin
          reg_write  = 1'b1;
          reg_dst    = DST_RA;
          mem_to_reg = M2R_PC;
        end
        state_d = S_FETCH;
      end
      S_JUMP_REG: begin
        pc_source = PCSRC_RS;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_TRAP);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed table, hand-written
// corner sequences and randomized instructions vs a step model.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, alu_zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       mem_req, mem_we, iord, ir_write, pc_write;
  logic       reg_write, alu_src_a, load_unsigned, busy, illegal_op;
  logic [1:0] mem_size, pc_source, reg_dst, mem_to_reg;
  logic [2:0] alu_src_b;
  logic [3:0] alu_op;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .load_unsigned(load_unsigned), .busy(busy),
    .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic       mem_req, mem_we;
    logic [1:0] mem_size;
    logic       iord, ir_write, pc_write, reg_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] reg_dst, mem_to_reg;
    logic       load_unsigned, busy, illegal_op;
  } outv_t;

  typedef struct {
    outv_t v;
    bit    mwait;
    bit    fetch;
  } step_t;

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    bit         z;
    int         wdata;
    int         cycles;
    outv_t      last;
  } vec_t;

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3;
  localparam int K_BR = 4, K_J = 5, K_JR = 6, K_ILL = 7;

  int      checks = 0;
  int      failures = 0;
  step_t   q[$];
  vec_t    tbl[12];
  logic [5:0] legal_ops[18] = '{6'h00, 6'h02, 6'h03, 6'h04,
    6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f,
    6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
  logic [5:0] legal_fns[15] = '{6'h00, 6'h02, 6'h03, 6'h08,
    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
    6'h2a, 6'h2b, 6'h08};

  function automatic outv_t sample();
    outv_t s;
    s.mem_req = mem_req;       s.mem_we = mem_we;
    s.mem_size = mem_size;     s.iord = iord;
    s.ir_write = ir_write;     s.pc_write = pc_write;
    s.reg_write = reg_write;   s.pc_source = pc_source;
    s.alu_src_a = alu_src_a;   s.alu_src_b = alu_src_b;
    s.alu_op = alu_op;         s.reg_dst = reg_dst;
    s.mem_to_reg = mem_to_reg; s.load_unsigned = load_unsigned;
    s.busy = busy;             s.illegal_op = illegal_op;
    return s;
  endfunction

  task automatic chk(string name, outv_t exp);
    outv_t a;
    a = sample();
    checks++;
    if (a !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, a, exp);
    end
  endtask

  function automatic outv_t bz();
    outv_t v;
    v = '0;
    v.busy = 1'b1;
    return v;
  endfunction

  function automatic int kind_of(logic [5:0] op, logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h08) return K_JR;
      if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27],
                     6'h2a, 6'h2b}) return K_R;
      return K_ILL;
    end
    if (op inside {6'h02, 6'h03}) return K_J;
    if (op inside {6'h04, 6'h05}) return K_BR;
    if (op inside {6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d,
                   6'h0f}) return K_I;
    if (op inside {6'h23, 6'h24, 6'h25}) return K_LD;
    if (op inside {6'h28, 6'h29, 6'h2b}) return K_ST;
    return K_ILL;
  endfunction

  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h20, 6'h21: return 4'd0;
      6'h22, 6'h23: return 4'd1;
      6'h24: return 4'd2;
      6'h25: return 4'd3;
      6'h26: return 4'd4;
      6'h27: return 4'd5;
      6'h2a: return 4'd6;
      6'h2b: return 4'd7;
      6'h00: return 4'd8;
      6'h02: return 4'd9;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(logic [5:0] op);
    case (op)
      6'h0a: return 4'd6;
      6'h0b: return 4'd7;
      6'h0c: return 4'd2;
      6'h0d: return 4'd3;
      6'h0f: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] sz_of(logic [5:0] op);
    if (op inside {6'h24, 6'h28}) return 2'b00;
    if (op inside {6'h25, 6'h29}) return 2'b01;
    return 2'b10;
  endfunction

  // Expected per-step output sequence for one instruction
  task automatic build(logic [5:0] op, logic [5:0] fn, bit z);
    outv_t v;
    int k;
    q.delete();
    v = bz(); v.mem_req = 1; v.mem_size = 2'b10;
    v.alu_src_b = 3'b001; v.ir_write = 1; v.pc_write = 1;
    q.push_back('{v, 1'b1, 1'b1});
    v = bz(); v.alu_src_b = 3'b100;
    q.push_back('{v, 1'b0, 1'b0});
    k = kind_of(op, fn);
    case (k)
      K_R, K_I: begin
        v = bz(); v.alu_src_a = 1;
        v.alu_op = (k == K_R) ? r_alu(fn) : i_alu(op);
        if (k == K_I)
          v.alu_src_b = (op inside {6'h0c, 6'h0d, 6'h0f}) ?
                        3'b011 : 3'b010;
        q.push_back('{v, 1'b0, 1'b0});
        v = bz(); v.reg_write = 1;
        v.reg_dst = (k == K_R) ? 2'b01 : 2'b00;
        q.push_back('{v, 1'b0, 1'b0});
      end
      K_LD, K_ST: begin
        v = bz(); v.alu_src_a = 1; v.alu_src_b = 3'b010;
        q.push_back('{v, 1'b0, 1'b0});
        v = bz(); v.mem_req = 1; v.iord = 1;
        v.mem_size = sz_of(op); v.mem_we = (k == K_ST);
        q.push_back('{v, 1'b1, 1'b0});
        if (k == K_LD) begin
          v = bz(); v.reg_write = 1; v.mem_to_reg = 2'b01;
          v.load_unsigned = (op inside {6'h24, 6'h25});
          q.push_back('{v, 1'b0, 1'b0});
        end
      end
      K_BR: begin
        v = bz(); v.alu_src_a = 1; v.alu_op = 4'd1;
        v.pc_source = 2'b01;
        v.pc_write = (op == 6'h04) ? z : !z;
        q.push_back('{v, 1'b0, 1'b0});
      end
      K_J: begin
        v = bz(); v.pc_source = 2'b10; v.pc_write = 1;
        if (op == 6'h03) begin
          v.reg_write = 1; v.reg_dst = 2'b10; v.mem_to_reg = 2'b10;
        end
        q.push_back('{v, 1'b0, 1'b0});
      end
      K_JR: begin
        v = bz(); v.pc_source = 2'b11; v.pc_write = 1;
        q.push_back('{v, 1'b0, 1'b0});
      end
      default: begin
        v = '0; v.illegal_op = 1;
        q.push_back('{v, 1'b0, 1'b0});
        q.push_back('{v, 1'b0, 1'b0});
        q.push_back('{v, 1'b0, 1'b0});
      end
    endcase
  endtask

  // Leaves the DUT in FETCH at edge+1
  task automatic do_reset(string tag);
    reset = 1; start = 0; mem_ready = 0;
    #1;
    @(negedge clk); chk({tag, "_idle"}, '0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk); chk({tag, "_hold"}, '0);
    start = 1;
    @(posedge clk); #1;
  endtask

  task automatic run_directed(vec_t t);
    int cnt, dw;
    bit done;
    outv_t last;
    cnt = 0; dw = 0; done = 0; last = '0;
    while (!done && cnt < 20) begin
      opcode = t.op; funct = t.fn; alu_zero = t.z;
      mem_ready = mem_req && (!iord || dw == t.wdata);
      if (mem_req && iord) dw++;
      @(negedge clk); last = sample(); cnt++;
      @(posedge clk); #1;
      if (mem_req && !iord) done = 1;
    end
    checks++;
    if (cnt != t.cycles) begin
      failures++;
      $display("FAIL %s_cycles got=%0d want=%0d",
               t.name, cnt, t.cycles);
    end
    checks++;
    if (last !== t.last) begin
      failures++;
      $display("FAIL %s_last got=%h want=%h",
               t.name, last, t.last);
    end
  endtask

  task automatic run_random(int n);
    logic [5:0] op, fn;
    bit z;
    int w;
    outv_t e;
    for (int i = 0; i < n; i++) begin
      op = ($urandom_range(0, 9) < 8) ?
           legal_ops[$urandom_range(0, 17)] : 6'($urandom);
      fn = ($urandom_range(0, 3) != 0) ?
           legal_fns[$urandom_range(0, 14)] : 6'($urandom);
      z = 1'($urandom);
      build(op, fn, z);
      for (int j = 0; j < q.size(); j++) begin
        w = q[j].mwait ? $urandom_range(0, 3) : 0;
        for (int k = 0; k <= w; k++) begin
          opcode = (j == 0) ? 6'($urandom) : op;
          funct  = (j == 0) ? 6'($urandom) : fn;
          alu_zero  = z;
          mem_ready = q[j].mwait ? (k == w) : 1'($urandom);
          e = q[j].v;
          if (q[j].fetch && k < w) begin
            e.ir_write = 0; e.pc_write = 0;
          end
          @(negedge clk);
          chk($sformatf("rand%0d_op%02h_fn%02h_s%0d",
                        i, op, fn, j), e);
          @(posedge clk); #1;
        end
      end
      if (kind_of(op, fn) == K_ILL) do_reset("rand_trap");
    end
  endtask

  task automatic set_tbl(int i, string nm, logic [5:0] op,
                         logic [5:0] fn, bit z, int wd, int cyc);
    tbl[i].name = nm; tbl[i].op = op; tbl[i].fn = fn;
    tbl[i].z = z; tbl[i].wdata = wd; tbl[i].cycles = cyc;
    tbl[i].last = bz();
  endtask

  initial begin
    outv_t e;
    reset = 1; start = 0; alu_zero = 0; mem_ready = 0;
    opcode = '0; funct = '0;

    set_tbl(0, "addu", 6'h00, 6'h21, 0, 0, 4);
    tbl[0].last.reg_write = 1; tbl[0].last.reg_dst = 2'b01;
    set_tbl(1, "lw_wait3", 6'h23, 6'h00, 0, 3, 8);
    tbl[1].last.reg_write = 1; tbl[1].last.mem_to_reg = 2'b01;
    set_tbl(2, "lbu", 6'h24, 6'h00, 0, 0, 5);
    tbl[2].last.reg_write = 1; tbl[2].last.mem_to_reg = 2'b01;
    tbl[2].last.load_unsigned = 1;
    set_tbl(3, "sw", 6'h2b, 6'h00, 0, 0, 4);
    tbl[3].last.mem_req = 1; tbl[3].last.mem_we = 1;
    tbl[3].last.iord = 1; tbl[3].last.mem_size = 2'b10;
    set_tbl(4, "sb_wait1", 6'h28, 6'h00, 0, 1, 5);
    tbl[4].last.mem_req = 1; tbl[4].last.mem_we = 1;
    tbl[4].last.iord = 1; tbl[4].last.mem_size = 2'b00;
    set_tbl(5, "beq_taken", 6'h04, 6'h00, 1, 0, 3);
    tbl[5].last.alu_src_a = 1; tbl[5].last.alu_op = 4'd1;
    tbl[5].last.pc_source = 2'b01; tbl[5].last.pc_write = 1;
    set_tbl(6, "bne_zero", 6'h05, 6'h00, 1, 0, 3);
    tbl[6].last.alu_src_a = 1; tbl[6].last.alu_op = 4'd1;
    tbl[6].last.pc_source = 2'b01;
    set_tbl(7, "jal", 6'h03, 6'h00, 0, 0, 3);
    tbl[7].last.pc_source = 2'b10; tbl[7].last.pc_write = 1;
    tbl[7].last.reg_write = 1; tbl[7].last.reg_dst = 2'b10;
    tbl[7].last.mem_to_reg = 2'b10;
    set_tbl(8, "jr", 6'h00, 6'h08, 0, 0, 3);
    tbl[8].last.pc_source = 2'b11; tbl[8].last.pc_write = 1;
    set_tbl(9, "ori", 6'h0d, 6'h00, 0, 0, 4);
    tbl[9].last.reg_write = 1;
    set_tbl(10, "sra", 6'h00, 6'h03, 0, 0, 4);
    tbl[10].last.reg_write = 1; tbl[10].last.reg_dst = 2'b01;
    set_tbl(11, "beq_not", 6'h04, 6'h00, 0, 0, 3);
    tbl[11].last.alu_src_a = 1; tbl[11].last.alu_op = 4'd1;
    tbl[11].last.pc_source = 2'b01;

    do_reset("reset");
    for (int i = 0; i < 12; i++) run_directed(tbl[i]);

    // Unsupported opcode: trap is sticky, start is ignored
    opcode = 6'h3f; funct = '0; mem_ready = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    e = '0; e.illegal_op = 1;
    for (int i = 0; i < 3; i++) begin
      start = (i == 1) ? 1'b0 : 1'b1;
      mem_ready = 1'($urandom);
      @(negedge clk); chk($sformatf("trap_hold%0d", i), e);
      @(posedge clk); #1;
    end
    do_reset("trap_clear");

    run_random(60);

    // Reset in the middle of an instruction fetch
    mem_ready = 0;
    e = bz(); e.mem_req = 1; e.mem_size = 2'b10;
    e.alu_src_b = 3'b001;
    @(negedge clk); chk("fetch_wait", e);
    #2 reset = 1;
    #1 chk("reset_mid_fetch", '0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk); chk("idle_after_reset", '0);
    @(posedge clk); #1;
    mem_ready = 1;
    e.ir_write = 1; e.pc_write = 1;
    @(negedge clk); chk("fetch_restart", e);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
